// File: rtl/seq_pattern_detector_pkg.sv
// Shared definitions for the serial pattern detector: FSM encoding and
// default sizing constants.
package seq_det_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } det_state_e;

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating event counter: clear wins over increment, holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // next count: clear has priority, increment stops at all-ones
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with runtime pattern/mask, overlap control and
// a saturating match counter.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_FILL  | fewer than PAT_W bits accepted since restart; no match yet
//   ST_ARMED | window holds PAT_W fresh bits; every accepted bit is compared
//
// rem_q counts down the bits still needed before a compare may fire; the
// terminal value 1 means the bit being accepted completes the window.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int                 PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0]   RST_PAT = PAT_W'(4'b1101),
  parameter int                 CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             clr_cnt,
  output logic [PAT_W-1:0] window,
  output logic             match,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               REM_W    = $clog2(PAT_W + 1);
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(PAT_W);
  localparam logic [REM_W-1:0] REM_LAST = REM_W'(1);

  logic [PAT_W-1:0] window_q, window_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] mask_q, mask_d;
  logic             ovl_q, ovl_d;
  logic             match_q, match_d;
  logic [REM_W-1:0] rem_q, rem_d;
  det_state_e       state_q, state_d;

  logic [PAT_W-1:0] nxt;
  logic             hit;

  // compare against the window as it will look after this bit is shifted in;
  // a load in the same cycle drops the bit, so it can never hit
  always_comb begin
    nxt = {window_q[PAT_W-2:0], in_bit};
    hit = in_valid && !cfg_load
          && (((nxt ^ pat_q) & mask_q) == '0)
          && (rem_q <= REM_LAST);
  end

  // next-state: config load restarts detection, accepted bits shift and arm
  always_comb begin
    window_d = window_q;
    pat_d    = pat_q;
    mask_d   = mask_q;
    ovl_d    = ovl_q;
    rem_d    = rem_q;
    state_d  = state_q;
    match_d  = 1'b0;

    if (cfg_load) begin
      pat_d    = cfg_pattern;
      mask_d   = cfg_mask;
      ovl_d    = cfg_overlap;
      window_d = '0;
      rem_d    = REM_FULL;
      state_d  = ST_FILL;
    end else if (in_valid) begin
      window_d = nxt;
      match_d  = hit;
      if (rem_q != '0) begin
        rem_d = rem_q - 1'b1;
      end
      case (state_q)
        ST_FILL: begin
          // the completing bit may itself hit; non-overlap then restarts fill
          if (hit && !ovl_q) begin
            rem_d = REM_FULL;
          end else if (rem_q == REM_LAST) begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (hit && !ovl_q) begin
            rem_d   = REM_FULL;
            state_d = ST_FILL;
          end
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

  // state and config registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q <= '0;
      pat_q    <= RST_PAT;
      mask_q   <= '1;
      ovl_q    <= 1'b1;
      rem_q    <= REM_FULL;
      state_q  <= ST_FILL;
      match_q  <= 1'b0;
    end else begin
      window_q <= window_d;
      pat_q    <= pat_d;
      mask_q   <= mask_d;
      ovl_q    <= ovl_d;
      rem_q    <= rem_d;
      state_q  <= state_d;
      match_q  <= match_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (clr_cnt),
    .q   (match_cnt)
  );

  assign window = window_q;
  assign match  = match_q;
  assign armed  = (state_q == ST_ARMED);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed table, hand sequences for the
// multi-cycle corners, then a randomized stream against a reference model.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = 4'b0;
  logic [3:0] cfg_mask = 4'b0;
  logic       cfg_overlap = 1'b0;
  logic       clr_cnt = 1'b0;

  logic [3:0] w1, w2;
  logic       m1, m2, a1, a2;
  logic [7:0] c1;
  logic [1:0] c2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(.PAT_W(4), .RST_PAT(4'b1101), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
    .window(w1), .match(m1), .armed(a1), .match_cnt(c1)
  );

  seq_pattern_detector #(.PAT_W(4), .RST_PAT(4'b1101), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
    .window(w2), .match(m2), .armed(a2), .match_cnt(c2)
  );

  // reference model: bits-since-restart count and a plain shift history
  logic [3:0] m_win, m_pat, m_mask;
  logic       m_ovl, m_match;
  int         m_since, m_cnt, m_cnt2;

  task automatic model_reset();
    m_win = 4'b0; m_pat = 4'b1101; m_mask = 4'b1111; m_ovl = 1'b1;
    m_match = 1'b0; m_since = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model_edge();
    m_match = 1'b0;
    if (cfg_load) begin
      m_pat = cfg_pattern; m_mask = cfg_mask; m_ovl = cfg_overlap;
      m_win = 4'b0; m_since = 0;
    end else if (in_valid) begin
      m_win = {m_win[2:0], in_bit};
      if (m_since < 4) m_since++;
      if (m_since == 4 && ((m_win ^ m_pat) & m_mask) == 4'b0) begin
        m_match = 1'b1;
        if (!m_ovl) m_since = 0;
      end
    end
    if (clr_cnt) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (m_match) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("window",     32'(w1), 32'(m_win));
    chk("match",      32'(m1), 32'(m_match));
    chk("armed",      32'(a1), 32'(m_since == 4));
    chk("match_cnt",  32'(c1), 32'(m_cnt));
    chk("sat.window", 32'(w2), 32'(m_win));
    chk("sat.match",  32'(m2), 32'(m_match));
    chk("sat.cnt",    32'(c2), 32'(m_cnt2));
  endtask

  task automatic step(input logic v, input logic b, input logic ld, input logic clr,
                      input logic [3:0] pat, input logic [3:0] mask, input logic ovl);
    in_valid = v; in_bit = b; cfg_load = ld; clr_cnt = clr;
    cfg_pattern = pat; cfg_mask = mask; cfg_overlap = ovl;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic bit_in(input logic b);
    step(1'b1, b, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
  endtask

  task automatic gap();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 0; in_bit = 0; cfg_load = 0; clr_cnt = 0;
    rst = 1'b1;
    #3;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic v, b, ld, ovl;
    logic [3:0] pat;
    logic e_match, e_armed;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic b, input logic ld,
                              input logic [3:0] pat, input logic ovl,
                              input logic em, input logic ea, input logic [7:0] ec);
    vec_t r;
    r.v = v; r.b = b; r.ld = ld; r.pat = pat; r.ovl = ovl;
    r.e_match = em; r.e_armed = ea; r.e_cnt = ec;
    return r;
  endfunction

  initial begin
    int nm;
    // reset defaults, 1101, then 1101101 with overlap on and off
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 1, 1, 8'd1));
    tbl.push_back(mk(0, 0, 1, 4'b1101, 1, 0, 0, 8'd1));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 1, 1, 8'd2));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 1, 8'd2));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 1, 8'd2));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 1, 1, 8'd3));
    tbl.push_back(mk(0, 0, 1, 4'b1101, 0, 0, 0, 8'd3));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd3));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd3));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 8'd3));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 1, 0, 8'd4));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd4));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 8'd4));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd4));

    do_reset();
    chk("reset.window", 32'(w1), 32'd0);
    chk("reset.armed",  32'(a1), 32'd0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].b, tbl[i].ld, 1'b0, tbl[i].pat, 4'b1111, tbl[i].ovl);
      chk($sformatf("tbl[%0d].match", i), 32'(m1), 32'(tbl[i].e_match));
      chk($sformatf("tbl[%0d].armed", i), 32'(a1), 32'(tbl[i].e_armed));
      chk($sformatf("tbl[%0d].cnt", i),   32'(c1), 32'(tbl[i].e_cnt));
    end

    // all-zero pattern: no match while filling, then on every further 0
    do_reset();
    step(0, 0, 1, 0, 4'b0000, 4'b1111, 1);
    for (int i = 0; i < 3; i++) begin
      bit_in(1'b0);
      chk("zero_pat.fill_match", 32'(m1), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      bit_in(1'b0);
      chk("zero_pat.armed_match", 32'(m1), 32'd1);
    end
    bit_in(1'b1);
    chk("zero_pat.one_bit", 32'(m1), 32'd0);

    // in_valid gaps: 1,_,1,_,0,1 gives one match; window holds in gaps
    do_reset();
    nm = 0;
    bit_in(1'b1); nm += int'(m1);
    gap();        nm += int'(m1);
    chk("gap.window_hold1", 32'(w1), 32'd1);
    bit_in(1'b1); nm += int'(m1);
    gap();        nm += int'(m1);
    chk("gap.window_hold2", 32'(w1), 32'd3);
    bit_in(1'b0); nm += int'(m1);
    bit_in(1'b1); nm += int'(m1);
    chk("gap.match_count", 32'(nm), 32'd1);
    chk("gap.cnt", 32'(c1), 32'd1);

    // masked compare, then load colliding with a valid bit
    do_reset();
    step(0, 0, 1, 0, 4'b1001, 4'b1001, 1);
    for (int i = 0; i < 4; i++) bit_in(1'b1);
    chk("mask.match", 32'(m1), 32'd1);
    chk("mask.cnt", 32'(c1), 32'd1);
    step(1, 1, 1, 0, 4'b1001, 4'b1001, 1);
    chk("load_drop.window", 32'(w1), 32'd0);
    chk("load_drop.armed", 32'(a1), 32'd0);
    chk("load_drop.match", 32'(m1), 32'd0);
    chk("load_drop.cnt", 32'(c1), 32'd1);

    // saturation at CNT_W=2, clear beating a match, async reset mid-stream
    do_reset();
    for (int r = 0; r < 5; r++) begin
      if (r == 0) bit_in(1'b1);
      bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    end
    chk("sat.cnt2_at_3", 32'(c2), 32'd3);
    chk("sat.cnt8_at_5", 32'(c1), 32'd5);
    bit_in(1'b1); bit_in(1'b0);
    step(1, 1, 0, 1, 4'b0, 4'b0, 0);
    chk("clr_vs_match.match", 32'(m1), 32'd1);
    chk("clr_vs_match.cnt8", 32'(c1), 32'd0);
    chk("clr_vs_match.cnt2", 32'(c2), 32'd0);
    bit_in(1'b1); bit_in(1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.window", 32'(w1), 32'd0);
    chk("async_rst.armed", 32'(a1), 32'd0);
    chk("async_rst.match", 32'(m1), 32'd0);
    chk("async_rst.cnt", 32'(c1), 32'd0);
    in_valid = 0; cfg_load = 0; clr_cnt = 0;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // randomized stream against the model
    for (int i = 0; i < 3000; i++) begin
      logic v, b, ld, clr, ovl;
      logic [3:0] pat, mask;
      v    = ($urandom_range(0, 3) != 0);
      b    = 1'($urandom);
      ld   = ($urandom_range(0, 63) == 0);
      clr  = ($urandom_range(0, 49) == 0);
      pat  = 4'($urandom);
      mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      ovl  = 1'($urandom);
      step(v, b, ld, clr, pat, mask, ovl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
